fsm_vector_sequencer: RTL

- Self-checking stimulus controller for a small Mealy FSM benchmark with 7 inputs and 9 outputs; the default widths match the knot2-class benchmarks.
- Holds a programmable table of input vectors and expected outputs, and owns the benchmark's reset.
- On `start`, replays N vectors into the FSM, compares each sampled output against its expected value, and reports mismatch count and first failing index.
- Used as the on-chip harness for functional and key-sequence checks of locked and unlocked FSM variants.

---
 rtl/fsm_vector_sequencer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/fsm_vector_sequencer.sv
// rtl/fsm_vector_sequencer.sv - vector table replay and response checker for a small Mealy FSM
module fsm_vector_sequencer #(
    parameter int IN_W  = 7,
    parameter int OUT_W = 9,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic [AW-1:0]    load_addr,
    input  logic [IN_W-1:0]  load_vec,
    input  logic [OUT_W-1:0] load_exp,
    input  logic             start,
    input  logic             abort,
    input  logic [AW:0]      num_vec,
    output logic             busy,
    output logic             done,
    output logic             dut_rst,
    output logic [IN_W-1:0]  dut_x,
    input  logic [OUT_W-1:0] dut_y,
    output logic [AW:0]      mismatch_cnt,
    output logic [AW-1:0]    first_fail,
    output logic             fail
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RSTD   = 3'd1;
    localparam logic [2:0] S_DRIVE  = 3'd2;
    localparam logic [2:0] S_SAMPLE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [IN_W-1:0]  vec_mem [DEPTH];
    logic [OUT_W-1:0] exp_mem [DEPTH];

    logic [2:0]    state;
    logic          rstd_cnt;
    logic [AW-1:0] idx;
    logic [AW-1:0] idx_inc;
    logic [AW:0]   run_len;
    logic [AW:0]   n_next;
    logic          last;

    assign n_next  = (num_vec > DEPTH_W) ? DEPTH_W : num_vec;
    assign idx_inc = idx + 1'b1;
    assign last    = (({1'b0, idx}) + (AW+1)'(1)) == run_len;

    // Table is intentionally not reset so contents survive a harness reset.
    always_ff @(posedge clk) begin
        if (load_en && !busy) begin
            vec_mem[load_addr] <= load_vec;
            exp_mem[load_addr] <= load_exp;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            rstd_cnt     <= 1'b0;
            idx          <= '0;
            run_len      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            dut_rst      <= 1'b1;
            dut_x        <= '0;
            mismatch_cnt <= '0;
            first_fail   <= '0;
            fail         <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != S_IDLE && abort) begin
                state   <= S_IDLE;
                busy    <= 1'b0;
                dut_rst <= 1'b1;
                dut_x   <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state        <= S_RSTD;
                            rstd_cnt     <= 1'b0;
                            busy         <= 1'b1;
                            dut_rst      <= 1'b1;
                            mismatch_cnt <= '0;
                            first_fail   <= '0;
                            fail         <= 1'b0;
                            idx          <= '0;
                            run_len      <= n_next;
                        end
                    end
                    S_RSTD: begin
                        if (!rstd_cnt) begin
                            rstd_cnt <= 1'b1;
                        end else if (run_len == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= S_DRIVE;
                            dut_x   <= vec_mem[idx];
                            dut_rst <= 1'b0;
                        end
                    end
                    S_DRIVE: state <= S_SAMPLE;
                    S_SAMPLE: begin
                        if (dut_y != exp_mem[idx]) begin
                            mismatch_cnt <= mismatch_cnt + 1'b1;
                            if (!fail) begin
                                first_fail <= idx;
                                fail       <= 1'b1;
                            end
                        end
                        if (last) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            idx   <= idx_inc;
                            state <= S_DRIVE;
                            dut_x <= vec_mem[idx_inc];
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
